fpu_req_arbiter: RTL and testbench

Shares one `fpu_top` instance between `NUM_REQ` requesters. Each requester uses a valid/ready request port, and the block round-robin arbitrates at most one issue per cycle. It drives the FPU operand/op/enable inputs and tracks in-flight operations through a fixed-latency tag pipeline. Results are buffered in a credit-protected response FIFO and returned with the originating requester ID over a valid/ready response port.

---
 rtl/fpu_req_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fpu_req_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: shares one fixed-latency FPU between NUM_REQ requesters.
// Round-robin picks at most one request per cycle. A tag pipeline follows each
// operation through the FPU, and the result lands in a response FIFO. Credits
// guarantee that every in-flight result has a free FIFO slot.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_*_i / req_ready_o per-requester valid/ready request port (operands, op)
//   fpu_*_o, alu_fpu_en_o operands/op/enable driven to the FPU
//   fpu_data_i            FPU result, valid FPU_LAT cycles after issue
//   rsp_*                 valid/ready response port with originating requester id
//   busy_o                any operation in flight or buffered
module fpu_req_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned FPU_LAT   = 1,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned IDW       = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0][31:0]      req_op_a_i,
    input  logic [NUM_REQ-1:0][31:0]      req_op_b_i,
    input  logic [NUM_REQ-1:0][1:0]       req_fpu_op_i,
    output logic [31:0]                   fpu_op_a_o,
    output logic [31:0]                   fpu_op_b_o,
    output logic [1:0]                    fpu_op_o,
    output logic                          alu_fpu_en_o,
    input  logic [31:0]                   fpu_data_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [31:0]                   rsp_data_o,
    output logic [IDW-1:0]                rsp_id_o,
    output logic                          busy_o
);

    localparam int unsigned PTRW = $clog2(RSP_DEPTH);
    localparam int unsigned CNTW = $clog2(RSP_DEPTH + 1);

    logic [IDW-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]                  cand;
    logic [IDW-1:0]                  grant_idx;
    logic                            grant_vld;
    logic                            can_issue;
    logic                            issue;

    logic [FPU_LAT-1:0]              tag_vld_q;
    logic [FPU_LAT-1:0][IDW-1:0]     tag_id_q;
    logic [CNTW-1:0]                 inflight_cnt;

    logic [RSP_DEPTH-1:0][31:0]      mem_data_q;
    logic [RSP_DEPTH-1:0][IDW-1:0]   mem_id_q;
    logic [PTRW-1:0]                 wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]                 fifo_cnt_q, fifo_cnt_d;
    logic                            push, pop;

    logic [31:0]                     op_a_q, op_b_q;
    logic [1:0]                      op_q;

    // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!grant_vld && req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Number of valid tag stages.
    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < FPU_LAT; i++) begin
            inflight_cnt = inflight_cnt + CNTW'(tag_vld_q[i]);
        end
    end

    // Credit uses the registered count, so a pop frees its slot only next cycle.
    assign can_issue = !rst_i &&
                       (({1'b0, fifo_cnt_q} + {1'b0, inflight_cnt}) < (CNTW + 1)'(RSP_DEPTH));
    assign issue     = grant_vld && can_issue;

    always_comb begin
        req_ready_o = '0;
        if (issue) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    // FPU inputs follow the granted requester during issue, else hold the last issue.
    assign alu_fpu_en_o = issue;
    assign fpu_op_a_o   = issue ? req_op_a_i[grant_idx]   : op_a_q;
    assign fpu_op_b_o   = issue ? req_op_b_i[grant_idx]   : op_b_q;
    assign fpu_op_o     = issue ? req_fpu_op_i[grant_idx] : op_q;

    assign rr_ptr_d = issue ? IDW'((32'(grant_idx) + 32'd1) % NUM_REQ) : rr_ptr_q;

    assign push = tag_vld_q[FPU_LAT-1];
    assign pop  = rsp_valid_o && rsp_ready_i;

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CNTW'(1);
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - CNTW'(1);
        end
    end

    // Arbitration pointer and held FPU operands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (issue) begin
                op_a_q <= req_op_a_i[grant_idx];
                op_b_q <= req_op_b_i[grant_idx];
                op_q   <= req_fpu_op_i[grant_idx];
            end
        end
    end

    // Tag pipeline mirroring the FPU latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q[0] <= issue;
            tag_id_q[0]  <= grant_idx;
            for (int unsigned i = 1; i < FPU_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    // Response FIFO storage and pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_data_q <= '0;
            mem_id_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= fpu_data_i;
                mem_id_q[wr_ptr_q]   <= tag_id_q[FPU_LAT-1];
                wr_ptr_q             <= wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTRW'(1);
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    assign rsp_valid_o = (fifo_cnt_q != '0);
    assign rsp_data_o  = mem_data_q[rd_ptr_q];
    assign rsp_id_o    = mem_id_q[rd_ptr_q];
    assign busy_o      = (inflight_cnt != '0) || (fifo_cnt_q != '0);

    // Credit accounting must never let a result arrive at a full FIFO.
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && (fifo_cnt_q == CNTW'(RSP_DEPTH))));

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter (NUM_REQ=2, FPU_LAT=1, RSP_DEPTH=4).
// A stand-in FPU registers a simple function of the issued operands one cycle
// after alu_fpu_en_o, and returns the true sum for the 1.0 + 2.0 case.
module tb_fpu_req_arbiter;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0][1:0]  req_op;
    logic [31:0]      fpu_a, fpu_b, fpu_data;
    logic [1:0]       fpu_op;
    logic             fpu_en;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_data;
    logic [0:0]       rsp_id;
    logic             busy;

    int n_pass = 0;
    int n_tot  = 0;

    fpu_req_arbiter #(
        .NUM_REQ   (2),
        .FPU_LAT   (1),
        .RSP_DEPTH (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_a_i   (req_a),
        .req_op_b_i   (req_b),
        .req_fpu_op_i (req_op),
        .fpu_op_a_o   (fpu_a),
        .fpu_op_b_o   (fpu_b),
        .fpu_op_o     (fpu_op),
        .alu_fpu_en_o (fpu_en),
        .fpu_data_i   (fpu_data),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_id_o     (rsp_id),
        .busy_o       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && op == 2'd0) return 32'h4040_0000;
        return a + b + {30'd0, op};
    endfunction

    // Stand-in FPU with one cycle of latency.
    always @(posedge clk) begin
        if (fpu_en) fpu_data <= fpu_model(fpu_a, fpu_b, fpu_op);
    end

    task automatic test_reset();
        @(negedge clk); #1;
        n_tot++;
        if ({req_ready, fpu_en, rsp_valid, busy} !== 5'b0)
            $display("FAIL reset_ctrl got=%b exp=00000", {req_ready, fpu_en, rsp_valid, busy});
        else n_pass++;
        n_tot++;
        if ({fpu_a, fpu_b, fpu_op} !== 66'b0)
            $display("FAIL reset_fpu_ops got=%h exp=0", {fpu_a, fpu_b, fpu_op});
        else n_pass++;
        n_tot++;
        if ({rsp_data, rsp_id} !== 33'b0)
            $display("FAIL reset_rsp got=%h exp=0", {rsp_data, rsp_id});
        else n_pass++;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 2'b00;
    endtask

    task automatic test_single_op();
        @(negedge clk);
        req_valid = 2'b10;
        req_a[1]  = 32'h3F80_0000;
        req_b[1]  = 32'h4000_0000;
        req_op[1] = 2'd0;
        rsp_ready = 1'b1;
        #1;
        n_tot++;
        if (req_ready !== 2'b10) $display("FAIL single_ready got=%b exp=10", req_ready);
        else n_pass++;
        n_tot++;
        if ({fpu_en, fpu_a, fpu_b, fpu_op} !== {1'b1, 32'h3F80_0000, 32'h4000_0000, 2'd0})
            $display("FAIL single_issue got=%h exp=%h", {fpu_en, fpu_a, fpu_b, fpu_op},
                     {1'b1, 32'h3F80_0000, 32'h4000_0000, 2'd0});
        else n_pass++;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_tot++;
        if ({fpu_en, rsp_valid, busy} !== 3'b001)
            $display("FAIL single_inflight got=%b exp=001", {fpu_en, rsp_valid, busy});
        else n_pass++;
        @(negedge clk); #1;
        n_tot++;
        if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid);
        else n_pass++;
        n_tot++;
        if (rsp_id !== 1'b1) $display("FAIL single_rsp_id got=%0d exp=1", rsp_id);
        else n_pass++;
        n_tot++;
        if (rsp_data !== 32'h4040_0000) $display("FAIL single_rsp_data got=%h exp=40400000", rsp_data);
        else n_pass++;
        n_tot++;
        if ({fpu_en, fpu_a} !== {1'b0, 32'h3F80_0000})
            $display("FAIL single_hold got=%h exp=%h", {fpu_en, fpu_a}, {1'b0, 32'h3F80_0000});
        else n_pass++;
        @(negedge clk); #1;
        n_tot++;
        if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_idle got=%b exp=00", {rsp_valid, busy});
        else n_pass++;
    endtask

    task automatic test_fairness();
        int          k0, k1, p;
        logic [1:0]  exp_rdy;
        logic [0:0]  exp_id;
        logic [31:0] exp_d;
        k0 = 0; k1 = 0; p = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = (c < 6) ? 2'b11 : 2'b00;
            req_a[0]  = 32'hA000_0000 + 32'(k0);
            req_a[1]  = 32'hA000_0100 + 32'(k1);
            req_b[0]  = 32'd1;
            req_b[1]  = 32'd1;
            req_op[0] = 2'd0;
            req_op[1] = 2'd1;
            rsp_ready = 1'b1;
            #1;
            if (c < 6) begin
                exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
                n_tot++;
                if ({req_ready, fpu_en} !== {exp_rdy, 1'b1})
                    $display("FAIL fair_grant c=%0d got=%b exp=%b", c, {req_ready, fpu_en}, {exp_rdy, 1'b1});
                else n_pass++;
            end
            if (req_ready[0]) k0++;
            if (req_ready[1]) k1++;
            if (rsp_valid) begin
                exp_id = 1'(p % 2);
                exp_d  = fpu_model(32'hA000_0000 + 32'((p % 2) * 256 + p / 2), 32'd1, 2'(p % 2));
                n_tot++;
                if (rsp_id !== exp_id) $display("FAIL fair_rsp_id p=%0d got=%0d exp=%0d", p, rsp_id, exp_id);
                else n_pass++;
                n_tot++;
                if (rsp_data !== exp_d) $display("FAIL fair_rsp_data p=%0d got=%h exp=%h", p, rsp_data, exp_d);
                else n_pass++;
                p++;
            end
        end
        n_tot++;
        if (p !== 6) $display("FAIL fair_rsp_count got=%0d exp=6", p);
        else n_pass++;
    endtask

    // Fill to 4 with the consumer stalled, then alternate pop-with-push (FIFO stays
    // at 3, no credit) and issue cycles, wrapping the pointers over 10 operations.
    task automatic test_backpressure();
        int          n, p;
        logic [1:0]  exp_rdy;
        logic [31:0] exp_d;
        n = 0; p = 0;
        for (int c = 0; c < 31; c++) begin
            @(negedge clk);
            req_valid = {1'b0, (n < 10)};
            req_a[0]  = 32'hB000_0000 + 32'(n);
            req_b[0]  = 32'h10;
            req_op[0] = 2'd0;
            rsp_ready = (c >= 8) && ((c > 20) || (c % 2 == 0));
            #1;
            if (c < 4)       exp_rdy = 2'b01;
            else if (c <= 8) exp_rdy = 2'b00;
            else if (c <= 20) exp_rdy = (c % 2 == 1) ? 2'b01 : 2'b00;
            else             exp_rdy = 2'b00;
            n_tot++;
            if ({req_ready, fpu_en} !== {exp_rdy, |exp_rdy})
                $display("FAIL bp_ready c=%0d got=%b exp=%b", c, {req_ready, fpu_en}, {exp_rdy, |exp_rdy});
            else n_pass++;
            if (req_ready[0]) n++;
            if (rsp_valid && rsp_ready) begin
                exp_d = fpu_model(32'hB000_0000 + 32'(p), 32'h10, 2'd0);
                n_tot++;
                if ({rsp_id, rsp_data} !== {1'b0, exp_d})
                    $display("FAIL bp_rsp p=%0d got=%h exp=%h", p, {rsp_id, rsp_data}, {1'b0, exp_d});
                else n_pass++;
                p++;
            end
        end
        n_tot++;
        if (p !== 10) $display("FAIL bp_rsp_count got=%0d exp=10", p);
        else n_pass++;
        n_tot++;
        if ({busy, rsp_valid} !== 2'b00) $display("FAIL bp_drained got=%b exp=00", {busy, rsp_valid});
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] exp_d;
        @(negedge clk);
        req_valid = 2'b01;
        req_a[0]  = 32'hC000_0000;
        req_b[0]  = 32'd5;
        req_op[0] = 2'd1;
        rsp_ready = 1'b0;
        #1;
        n_tot++;
        if (req_ready !== 2'b01) $display("FAIL rst_issue got=%b exp=01", req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_tot++;
        if (busy !== 1'b1) $display("FAIL rst_busy_before got=%b exp=1", busy);
        else n_pass++;
        #1;
        rst       = 1'b1;
        req_valid = 2'b11;
        #1;
        n_tot++;
        if ({req_ready, fpu_en, rsp_valid, busy} !== 5'b0)
            $display("FAIL rst_async_ctrl got=%b exp=00000", {req_ready, fpu_en, rsp_valid, busy});
        else n_pass++;
        n_tot++;
        if ({fpu_a, fpu_b, fpu_op, rsp_data, rsp_id} !== 99'b0)
            $display("FAIL rst_async_data got=%h exp=0", {fpu_a, fpu_b, fpu_op, rsp_data, rsp_id});
        else n_pass++;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            n_tot++;
            if ({rsp_valid, busy} !== 2'b00)
                $display("FAIL rst_no_rsp c=%0d got=%b exp=00", c, {rsp_valid, busy});
            else n_pass++;
        end
        @(negedge clk);
        req_valid = 2'b11;
        req_a[0]  = 32'hD000_0000;
        req_b[0]  = 32'd7;
        req_op[0] = 2'd2;
        req_a[1]  = 32'hE000_0000;
        #1;
        n_tot++;
        if (req_ready !== 2'b01) $display("FAIL rst_rr_restart got=%b exp=01", req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #1;
        exp_d = fpu_model(32'hD000_0000, 32'd7, 2'd2);
        n_tot++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, exp_d})
            $display("FAIL rst_after_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, exp_d});
        else n_pass++;
        @(negedge clk); #1;
        n_tot++;
        if (busy !== 1'b0) $display("FAIL rst_after_idle got=%b exp=0", busy);
        else n_pass++;
    endtask

    task automatic test_valid_withdrawn();
        int          n0, p;
        logic        got1;
        logic [1:0]  exp_rdy;
        logic [31:0] exp_d;
        logic [0:0]  exp_id;
        n0 = 0; p = 0; got1 = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            req_valid[0] = (c < 6);
            req_valid[1] = (c >= 7) && !got1;
            req_a[0]     = 32'hF000_0000 + 32'(n0);
            req_b[0]     = 32'd3;
            req_op[0]    = 2'd0;
            req_a[1]     = 32'hF100_0000;
            req_b[1]     = 32'd3;
            req_op[1]    = 2'd1;
            rsp_ready    = (c == 7) || (c >= 9);
            #1;
            if (c < 4)       exp_rdy = 2'b01;
            else if (c <= 7) exp_rdy = 2'b00;
            else if (c == 8) exp_rdy = 2'b10;
            else             exp_rdy = 2'b00;
            n_tot++;
            if ({req_ready, fpu_en} !== {exp_rdy, |exp_rdy})
                $display("FAIL wd_ready c=%0d got=%b exp=%b", c, {req_ready, fpu_en}, {exp_rdy, |exp_rdy});
            else n_pass++;
            if (c == 8) begin
                n_tot++;
                if (fpu_a !== 32'hF100_0000) $display("FAIL wd_req1_ops got=%h exp=f1000000", fpu_a);
                else n_pass++;
            end
            if (req_ready[0]) n0++;
            if (req_ready[1]) got1 = 1'b1;
            if (rsp_valid && rsp_ready) begin
                exp_id = (p < 4) ? 1'b0 : 1'b1;
                exp_d  = (p < 4) ? fpu_model(32'hF000_0000 + 32'(p), 32'd3, 2'd0)
                                 : fpu_model(32'hF100_0000, 32'd3, 2'd1);
                n_tot++;
                if ({rsp_id, rsp_data} !== {exp_id, exp_d})
                    $display("FAIL wd_rsp p=%0d got=%h exp=%h", p, {rsp_id, rsp_data}, {exp_id, exp_d});
                else n_pass++;
                p++;
            end
        end
        n_tot++;
        if (p !== 5) $display("FAIL wd_rsp_count got=%0d exp=5", p);
        else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        fpu_data  = '0;
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        test_valid_withdrawn();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
